// File: rtl/inv_sqrt_pkg.sv
// Shared types for the inverse-square-root datapath and its output collector.
// Entry layout is {sample index, IEEE-754 result}.
package inv_sqrt_pkg;

    localparam int FP_W      = 32;
    localparam int IDX_W_DEF = 10;

    typedef struct packed {
        logic [IDX_W_DEF-1:0] index;
        logic [FP_W-1:0]      data;
    } entry_t;

endpackage

// File: rtl/inv_sqrt_out_buffer_if.sv
// Result-ingest and consumer-handshake bundle of the output collector.
// The slave side is the buffer; the master side is the core/consumer environment.
interface inv_sqrt_out_buffer_if #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int IDX_W = 10,
    parameter int CNT_W = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             Clear;
    logic [WIDTH-1:0] DataIn;
    logic             DataInValid;
    logic [WIDTH-1:0] DataOut;
    logic [IDX_W-1:0] IndexOut;
    logic             OutValid;
    logic             OutReady;
    logic [LVL_W-1:0] Level;
    logic             Full;
    logic             Empty;
    logic             Overflow;
    logic [CNT_W-1:0] DropCount;

    modport master (
        output Clear, DataIn, DataInValid, OutReady,
        input  DataOut, IndexOut, OutValid, Level, Full, Empty, Overflow, DropCount
    );

    modport slave (
        input  Clear, DataIn, DataInValid, OutReady,
        output DataOut, IndexOut, OutValid, Level, Full, Empty, Overflow, DropCount
    );

endinterface

// File: rtl/inv_sqrt_fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
// Storage only; no reset, occupancy is tracked by the caller.
module inv_sqrt_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 42
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdat,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdat
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdat;
        end
    end

    assign rdat = mem_q[raddr];

endmodule

// File: rtl/inv_sqrt_out_buffer.sv
// FWFT collector for InvertSQRoot results, tagging each with its sample index.
// Never stalls the core: results arriving while full are dropped and counted.
module inv_sqrt_out_buffer
    import inv_sqrt_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = FP_W,
    parameter int IDX_W = IDX_W_DEF,
    parameter int CNT_W = 16
) (
    input logic                  clk,
    input logic                  rst,
    inv_sqrt_out_buffer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = IDX_W + WIDTH;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic             full, empty, push, pop, drop, wr_en;
    logic [ENT_W-1:0] rd_entry;

    always_comb begin
        full  = (level_q == LVL_FULL);
        empty = (level_q == '0);
        pop   = !empty && bus.OutReady;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push  = bus.DataInValid && (!full || pop);
        drop  = bus.DataInValid && full && !pop;

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);

        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        idx_d = idx_q + IDX_W'(bus.DataInValid);
        ovf_d = ovf_q | drop;

        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || bus.Clear) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            idx_q      <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            idx_q      <= idx_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Writes during reset/Clear are suppressed so flushed entries never reappear.
    assign wr_en = push && rst && !bus.Clear;

    inv_sqrt_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdat  ({idx_q, bus.DataIn}),
        .raddr (rd_ptr_q),
        .rdat  (rd_entry)
    );

    assign bus.DataOut   = rd_entry[WIDTH-1:0];
    assign bus.IndexOut  = rd_entry[ENT_W-1:WIDTH];
    assign bus.OutValid  = !empty;
    assign bus.Level     = level_q;
    assign bus.Full      = full;
    assign bus.Empty     = empty;
    assign bus.Overflow  = ovf_q;
    assign bus.DropCount = drop_cnt_q;

endmodule

// File: tb/tb_inv_sqrt_out_buffer.sv
// Directed bench for inv_sqrt_out_buffer: queue-based reference model plus literal spot checks.
// A small second instance exercises counter saturation and index wrap.
module tb_inv_sqrt_out_buffer;
    import inv_sqrt_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    inv_sqrt_out_buffer_if #(.DEPTH(16), .WIDTH(32), .IDX_W(10), .CNT_W(16)) bus ();
    inv_sqrt_out_buffer_if #(.DEPTH(4),  .WIDTH(32), .IDX_W(4),  .CNT_W(4))  bus_s ();

    inv_sqrt_out_buffer #(.DEPTH(16), .WIDTH(32), .IDX_W(10), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    inv_sqrt_out_buffer #(.DEPTH(4), .WIDTH(32), .IDX_W(4), .CNT_W(4)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s.slave)
    );

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;
    bit pt_phase = 1'b0;

    // Reference model of the main instance.
    entry_t m_q[$];
    int     m_idx  = 0;
    bit     m_ovf  = 1'b0;
    int     m_drop = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit     m_pop, m_full;
        entry_t e;
        if (!rst || bus.Clear) begin
            m_q.delete();
            m_idx  = 0;
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            m_pop  = (m_q.size() > 0) && bus.OutReady;
            m_full = (m_q.size() == 16);
            if (m_pop) void'(m_q.pop_front());
            if (bus.DataInValid) begin
                if (!m_full || m_pop) begin
                    e.index = m_idx[9:0];
                    e.data  = bus.DataIn;
                    m_q.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end
                m_idx = (m_idx + 1) % 1024;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("level",     64'(bus.Level),     64'(m_q.size()));
            chk("empty",     64'(bus.Empty),     64'(m_q.size() == 0));
            chk("full",      64'(bus.Full),      64'(m_q.size() == 16));
            chk("outvalid",  64'(bus.OutValid),  64'(m_q.size() != 0));
            chk("overflow",  64'(bus.Overflow),  64'(m_ovf));
            chk("dropcount", 64'(bus.DropCount), 64'(m_drop));
            if (m_q.size() != 0) begin
                chk("dataout",  64'(bus.DataOut),  64'(m_q[0].data));
                chk("indexout", 64'(bus.IndexOut), 64'(m_q[0].index));
            end
            if (pt_phase) chk("level_le1", 64'(bus.Level <= 1), 64'(1));
        end
    end

    task automatic step(input bit v, input logic [31:0] d, input bit r);
        bus.DataInValid = v;
        bus.DataIn      = d;
        bus.OutReady    = r;
        @(negedge clk);
    endtask

    task automatic step_s(input bit v, input logic [31:0] d, input bit r);
        bus_s.DataInValid = v;
        bus_s.DataIn      = d;
        bus_s.OutReady    = r;
        @(negedge clk);
    endtask

    task automatic pulse_rst();
        rst = 1'b0;
        step(1'b1, 32'h5555_5555, 1'b0);
        rst = 1'b1;
    endtask

    initial begin
        bus.Clear = 1'b0;   bus.DataIn = '0;   bus.DataInValid = 1'b0;   bus.OutReady = 1'b0;
        bus_s.Clear = 1'b0; bus_s.DataIn = '0; bus_s.DataInValid = 1'b0; bus_s.OutReady = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check_en = 1'b1;
        chk("rst_empty",    64'(bus.Empty),    64'(1));
        chk("rst_level",    64'(bus.Level),    64'(0));
        chk("rst_outvalid", 64'(bus.OutValid), 64'(0));
        chk("rst_full",     64'(bus.Full),     64'(0));

        // Pass-through
        pt_phase = 1'b1;
        for (int i = 0; i < 1000; i++) step(1'b1, 32'h3F00_0000 + 32'(i * 7), 1'b1);
        step(1'b0, 32'h0, 1'b1);
        pt_phase = 1'b0;
        chk("pt_overflow", 64'(bus.Overflow), 64'(0));
        chk("pt_empty",    64'(bus.Empty),    64'(1));

        // Fill to full, then drop one
        pulse_rst();
        for (int i = 0; i < 16; i++) step(1'b1, 32'h3F80_0000 + 32'(i), 1'b0);
        chk("fill_full",  64'(bus.Full),  64'(1));
        chk("fill_level", 64'(bus.Level), 64'(16));
        step(1'b1, 32'h4000_0000, 1'b0);
        chk("drop_ovf",   64'(bus.Overflow),  64'(1));
        chk("drop_cnt",   64'(bus.DropCount), 64'(1));
        chk("drop_level", 64'(bus.Level),     64'(16));
        for (int i = 0; i < 16; i++) begin
            chk("drain_idx",  64'(bus.IndexOut), 64'(i));
            chk("drain_data", 64'(bus.DataOut),  64'(32'h3F80_0000 + 32'(i)));
            step(1'b0, 32'h0, 1'b1);
        end
        chk("drain_empty", 64'(bus.Empty), 64'(1));
        step(1'b1, 32'h4040_0000, 1'b0);
        chk("next_idx",   64'(bus.IndexOut), 64'(17));
        chk("next_valid", 64'(bus.OutValid), 64'(1));

        // Full with simultaneous push and pop
        for (int i = 0; i < 15; i++) step(1'b1, 32'h3F00_0100 + 32'(i), 1'b0);
        chk("pp_full", 64'(bus.Full), 64'(1));
        step(1'b1, 32'hABCD_0000, 1'b1);
        chk("pp_level", 64'(bus.Level),     64'(16));
        chk("pp_drop",  64'(bus.DropCount), 64'(1));
        chk("pp_head",  64'(bus.DataOut),   64'(32'h3F00_0100));
        repeat (15) step(1'b0, 32'h0, 1'b1);
        chk("pp_last_data", 64'(bus.DataOut),  64'(32'hABCD_0000));
        chk("pp_last_idx",  64'(bus.IndexOut), 64'(33));
        chk("pp_last_lvl",  64'(bus.Level),    64'(1));
        step(1'b0, 32'h0, 1'b1);

        // Clear mid-stream (Overflow is still set from the drop above)
        for (int i = 0; i < 5; i++) step(1'b1, 32'h3E00_0000 + 32'(i), 1'b0);
        chk("clr_pre_level", 64'(bus.Level),    64'(5));
        chk("clr_pre_ovf",   64'(bus.Overflow), 64'(1));
        bus.Clear = 1'b1;
        step(1'b1, 32'hDEAD_BEEF, 1'b0);
        bus.Clear = 1'b0;
        chk("clr_empty", 64'(bus.Empty),     64'(1));
        chk("clr_level", 64'(bus.Level),     64'(0));
        chk("clr_ovf",   64'(bus.Overflow),  64'(0));
        chk("clr_drop",  64'(bus.DropCount), 64'(0));
        step(1'b1, 32'h1111_1111, 1'b0);
        chk("clr_idx0",  64'(bus.IndexOut), 64'(0));
        chk("clr_data",  64'(bus.DataOut),  64'(32'h1111_1111));

        // Same with reset mid-stream
        for (int i = 0; i < 4; i++) step(1'b1, 32'h3D00_0000 + 32'(i), 1'b0);
        chk("rst_pre_level", 64'(bus.Level), 64'(5));
        pulse_rst();
        chk("rst_mid_empty", 64'(bus.Empty), 64'(1));
        chk("rst_mid_level", 64'(bus.Level), 64'(0));
        step(1'b1, 32'h2222_2222, 1'b0);
        chk("rst_mid_idx0", 64'(bus.IndexOut), 64'(0));
        step(1'b0, 32'h0, 1'b1);

        // Small instance: drop-counter saturation
        pulse_rst();
        step(1'b0, 32'h0, 1'b0);
        chk("s_rst_empty", 64'(bus_s.Empty), 64'(1));
        for (int i = 0; i < 24; i++) step_s(1'b1, 32'(i), 1'b0);
        chk("s_sat_cnt",   64'(bus_s.DropCount), 64'(15));
        chk("s_sat_ovf",   64'(bus_s.Overflow),  64'(1));
        chk("s_sat_full",  64'(bus_s.Full),      64'(1));
        chk("s_sat_level", 64'(bus_s.Level),     64'(4));
        chk("s_sat_head",  64'(bus_s.IndexOut),  64'(0));

        // Small instance: index wrap
        pulse_rst();
        for (int i = 0; i < 16; i++) step_s(1'b1, 32'd100 + 32'(i), 1'b1);
        chk("s_wrap_idx15",  64'(bus_s.IndexOut), 64'(15));
        step_s(1'b1, 32'd116, 1'b1);
        chk("s_wrap_idx0",   64'(bus_s.IndexOut), 64'(0));
        chk("s_wrap_data",   64'(bus_s.DataOut),  64'(116));
        chk("s_wrap_lvl",    64'(bus_s.Level),    64'(1));
        chk("s_wrap_nodrop", 64'(bus_s.DropCount), 64'(0));
        step_s(1'b0, 32'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
